// File: rtl/axi_crossbar_nx1_if.sv
// rtl/axi_crossbar_nx1_if.sv - flattened AXI4 bus bundle for N ports; port i occupies slice [i*W +: W]
interface axi_crossbar_nx1_if #(
  parameter int N   = 1,
  parameter int IDW = 8,
  parameter int AW  = 32,
  parameter int DW  = 64
);
  logic [N*IDW-1:0]  awid;
  logic [N*AW-1:0]   awaddr;
  logic [N*8-1:0]    awlen;
  logic [N*3-1:0]    awsize;
  logic [N*2-1:0]    awburst;
  logic [N-1:0]      awvalid;
  logic [N-1:0]      awready;
  logic [N*DW-1:0]   wdata;
  logic [N*DW/8-1:0] wstrb;
  logic [N-1:0]      wlast;
  logic [N-1:0]      wvalid;
  logic [N-1:0]      wready;
  logic [N*IDW-1:0]  bid;
  logic [N*2-1:0]    bresp;
  logic [N-1:0]      bvalid;
  logic [N-1:0]      bready;
  logic [N*IDW-1:0]  arid;
  logic [N*AW-1:0]   araddr;
  logic [N*8-1:0]    arlen;
  logic [N*3-1:0]    arsize;
  logic [N*2-1:0]    arburst;
  logic [N-1:0]      arvalid;
  logic [N-1:0]      arready;
  logic [N*IDW-1:0]  rid;
  logic [N*DW-1:0]   rdata;
  logic [N*2-1:0]    rresp;
  logic [N-1:0]      rlast;
  logic [N-1:0]      rvalid;
  logic [N-1:0]      rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_crossbar_nx1.sv
// rtl/axi_crossbar_nx1.sv - NM-master to 1-slave AXI4 crossbar, independent round-robin write/read paths
// AXI_XBAR_STATS_EN adds wr_txn_cnt/rd_txn_cnt completed-transaction counters
module axi_crossbar_nx1 #(
  parameter int NM  = 2,
  parameter int IDW = 8,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic aclk,
  input  logic aresetn,
`ifdef AXI_XBAR_STATS_EN
  output logic [31:0] wr_txn_cnt,
  output logic [31:0] rd_txn_cnt,
`endif
  axi_crossbar_nx1_if.slave  m,
  axi_crossbar_nx1_if.master s
);
  localparam int PW = $clog2(NM);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t       wstate;
  rstate_t       rstate;
  logic [PW-1:0] wgnt, rgnt, wr_ptr, rd_ptr;
  int            wi, ri;
  logic          aw_hs, w_last_hs, b_hs, ar_hs, r_last_hs;

  // First requester at or after ptr, wrapping modulo NM.
  function automatic logic [PW-1:0] rr_pick(input logic [NM-1:0] req, input logic [PW-1:0] ptr);
    logic [PW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int i = NM - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NM;
      if (req[idx]) pick = PW'(idx);
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
    return (int'(g) == NM - 1) ? '0 : g + PW'(1);
  endfunction

  assign wi        = int'(wgnt);
  assign ri        = int'(rgnt);
  assign aw_hs     = s.awvalid[0] & s.awready[0];
  assign w_last_hs = s.wvalid[0] & s.wready[0] & s.wlast[0];
  assign b_hs      = s.bvalid[0] & s.bready[0];
  assign ar_hs     = s.arvalid[0] & s.arready[0];
  assign r_last_hs = s.rvalid[0] & s.rready[0] & s.rlast[0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate <= W_IDLE;
      wgnt   <= '0;
      wr_ptr <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (|m.awvalid) begin
          wgnt   <= rr_pick(m.awvalid, wr_ptr);
          wstate <= W_ADDR;
        end
        W_ADDR: if (aw_hs) wstate <= W_DATA;
        W_DATA: if (w_last_hs) wstate <= W_RESP;
        W_RESP: if (b_hs) begin
          wr_ptr <= rr_next(wgnt);
          wstate <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rstate <= R_IDLE;
      rgnt   <= '0;
      rd_ptr <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (|m.arvalid) begin
          rgnt   <= rr_pick(m.arvalid, rd_ptr);
          rstate <= R_ADDR;
        end
        R_ADDR: if (ar_hs) rstate <= R_DATA;
        R_DATA: if (r_last_hs) begin
          rd_ptr <= rr_next(rgnt);
          rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  // Only the granted slice is routed; everything else stays zero.
  always_comb begin
    s.awid    = '0;
    s.awaddr  = '0;
    s.awlen   = '0;
    s.awsize  = '0;
    s.awburst = '0;
    s.awvalid = '0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wlast   = '0;
    s.wvalid  = '0;
    s.bready  = '0;
    m.awready = '0;
    m.wready  = '0;
    m.bvalid  = '0;
    m.bid     = '0;
    m.bresp   = '0;
    case (wstate)
      W_ADDR: begin
        s.awid       = m.awid[wi*IDW +: IDW];
        s.awaddr     = m.awaddr[wi*AW +: AW];
        s.awlen      = m.awlen[wi*8 +: 8];
        s.awsize     = m.awsize[wi*3 +: 3];
        s.awburst    = m.awburst[wi*2 +: 2];
        s.awvalid[0] = m.awvalid[wi];
        m.awready[wi] = s.awready[0];
      end
      W_DATA: begin
        s.wdata      = m.wdata[wi*DW +: DW];
        s.wstrb      = m.wstrb[wi*SW +: SW];
        s.wlast[0]   = m.wlast[wi];
        s.wvalid[0]  = m.wvalid[wi];
        m.wready[wi] = s.wready[0];
      end
      W_RESP: begin
        m.bvalid[wi]          = s.bvalid[0];
        m.bid[wi*IDW +: IDW]  = s.bid;
        m.bresp[wi*2 +: 2]    = s.bresp;
        s.bready[0]           = m.bready[wi];
      end
      default: ;
    endcase
  end

  always_comb begin
    s.arid    = '0;
    s.araddr  = '0;
    s.arlen   = '0;
    s.arsize  = '0;
    s.arburst = '0;
    s.arvalid = '0;
    s.rready  = '0;
    m.arready = '0;
    m.rvalid  = '0;
    m.rlast   = '0;
    m.rid     = '0;
    m.rresp   = '0;
    m.rdata   = '0;
    case (rstate)
      R_ADDR: begin
        s.arid        = m.arid[ri*IDW +: IDW];
        s.araddr      = m.araddr[ri*AW +: AW];
        s.arlen       = m.arlen[ri*8 +: 8];
        s.arsize      = m.arsize[ri*3 +: 3];
        s.arburst     = m.arburst[ri*2 +: 2];
        s.arvalid[0]  = m.arvalid[ri];
        m.arready[ri] = s.arready[0];
      end
      R_DATA: begin
        m.rvalid[ri]         = s.rvalid[0];
        m.rlast[ri]          = s.rlast[0];
        m.rid[ri*IDW +: IDW] = s.rid;
        m.rresp[ri*2 +: 2]   = s.rresp;
        m.rdata[ri*DW +: DW] = s.rdata;
        s.rready[0]          = m.rready[ri];
      end
      default: ;
    endcase
  end

`ifdef AXI_XBAR_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_txn_cnt <= '0;
      rd_txn_cnt <= '0;
    end else begin
      if (b_hs)      wr_txn_cnt <= wr_txn_cnt + 32'd1;
      if (r_last_hs) rd_txn_cnt <= rd_txn_cnt + 32'd1;
    end
  end
`else
`endif
endmodule
